// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, sanity words, receiver FSM states.
package uart_pkg;

  localparam logic [1:0] REG_DIVIDER = 2'd0;
  localparam logic [1:0] REG_DATA    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_SANITY  = 2'd3;

  localparam logic [31:0] RX_SANITY_VALUE = 32'h5EC0B0B1;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned UART_DATA_BITS  = UART_FRAME_BITS - 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  typedef struct packed {
    logic [23:0] rsvd_hi;
    logic [4:0]  level;
    logic        rsvd_lo;
    logic        frame_err;
    logic        overrun;
  } rx_status_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; extra pointer bit separates full from empty.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [FIFO_DEPTH_LOG2:0] level
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [7:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic                     do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_DEPTH_LOG2] != rd_ptr_q[FIFO_DEPTH_LOG2]) &&
                 (wr_ptr_q[FIFO_DEPTH_LOG2-1:0] == rd_ptr_q[FIFO_DEPTH_LOG2-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone-slave 8N1 UART receiver with RX FIFO, sticky error flags and interrupt.
module wb_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH   = 32,
  parameter int unsigned WB_ADDR_WIDTH   = 32,
  parameter int unsigned WB_SEL_WIDTH    = WB_DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     uart_rx_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     rx_irq_o
);

  localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;

  logic             sync1_q, sync2_q;
  rx_state_e        state_q, state_d;
  logic [31:0]      cnt_q, cnt_d, div_q, div_lat_q, div_lat_d, period_c, half_c;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             brk_q, brk_d;
  logic             push_c, ferr_set_c;
  logic             ack_q, acc_c, pop_c, wr_status_c;
  logic [1:0]       reg_sel;
  logic             overrun_q, frame_err_q, irq_q;
  logic [31:0]      rdata_q, rd_data_c;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  rx_status_t       status_c;
  logic             unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0]};

  // Two-flop synchronizer; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign period_c = div_lat_q + 32'd2;
  assign half_c   = period_c >> 1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      brk_q     <= 1'b0;
      div_lat_q <= 32'd1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      div_lat_q <= div_lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    brk_d      = brk_q;
    div_lat_d  = div_lat_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d   = START;
          div_lat_d = div_q;
        end
      end
      START: begin
        if (cnt_q == half_c - 32'd1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == period_c - 32'd1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // After a framing error, hold here until the line returns to idle.
        if (brk_q) begin
          cnt_d = '0;
          if (sync2_q) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == period_c - 32'd1) begin
          cnt_d = '0;
          if (sync2_q) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set_c = 1'b1;
            brk_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_c       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign reg_sel     = wb_addr_i[3:2];
  assign pop_c       = acc_c & ~wb_we_i & (reg_sel == REG_DATA);
  assign wr_status_c = acc_c & wb_we_i & (reg_sel == REG_STATUS);

  uart_rx_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_c),
    .din   (shift_q),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign status_c = '{rsvd_hi: '0, level: 5'(fifo_level), rsvd_lo: 1'b0,
                      frame_err: frame_err_q, overrun: overrun_q};

  always_comb begin
    rd_data_c = '0;
    case (reg_sel)
      REG_DIVIDER: rd_data_c = div_q;
      REG_DATA:    rd_data_c = fifo_empty ? 32'd0 : {23'd0, 1'b1, fifo_dout};
      REG_STATUS:  rd_data_c = 32'(status_c);
      REG_SANITY:  rd_data_c = RX_SANITY_VALUE;
      default:     rd_data_c = '0;
    endcase
  end

  // Bus registers; a set event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      div_q       <= 32'd1;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ack_q   <= acc_c;
      rdata_q <= (acc_c & ~wb_we_i) ? rd_data_c : 32'd0;
      if (acc_c && wb_we_i && reg_sel == REG_DIVIDER) div_q <= 32'(wb_data_i);
      overrun_q   <= (push_c & fifo_full & ~pop_c) |
                     (overrun_q & ~(wr_status_c & wb_data_i[0]));
      frame_err_q <= ferr_set_c | (frame_err_q & ~(wr_status_c & wb_data_i[1]));
      irq_q       <= ~fifo_empty | overrun_q | frame_err_q;
    end
  end

  assign wb_ack_o  = ack_q & wb_cyc_i;
  assign wb_data_o = WB_DATA_WIDTH'(rdata_q);
  assign rx_irq_o  = irq_q;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Randomized scoreboard bench for wb_uart_rx against a queue-based receiver model.
module tb_wb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic [31:0] wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;
  logic        rx_irq_o;

  wb_uart_rx dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .uart_rx_i (uart_rx_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_ack_o  (wb_ack_o),
    .wb_data_o (wb_data_o),
    .rx_irq_o  (rx_irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          we;
    logic [31:0] d;
    string       nm;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] mq[$];
  bit         m_ovr = 0, m_ferr = 0;
  int         m_div = 1;
  int         n_cmp = 0, n_fail = 0;

  function automatic logic [31:0] status_exp();
    return (32'(mq.size()) << 3) | (32'(m_ferr) << 1) | 32'(m_ovr);
  endfunction

  function automatic logic [31:0] rx_exp();
    logic [7:0] b;
    if (mq.size() == 0) return 32'd0;
    b = mq.pop_front();
    return {23'd0, 1'b1, b};
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (mq.size() >= 8) m_ovr = 1;
    else mq.push_back(b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops the oldest expected access and checks read data.
  always @(negedge clk_i) begin
    sb_t e;
    if (!rst_i && wb_ack_o) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_ack: got ack with no access pending");
      end else begin
        e = sb_q.pop_front();
        if (!e.we) begin
          n_cmp++;
          if (wb_data_o !== e.d) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, wb_data_o, e.d);
          end
        end
      end
    end
  end

  task automatic bus(input bit we, input int off, input logic [31:0] wd,
                     input logic [31:0] exp, input string nm);
    sb_t e;
    e.we = we; e.d = exp; e.nm = nm;
    sb_q.push_back(e);
    wb_addr_i = 32'(off) << 2;
    wb_data_i = wd;
    wb_we_i   = we;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (wb_ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ack: got %b expected 1", nm, wb_ack_o);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    @(posedge clk_i);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = fr[i];
      repeat (m_div + 2) @(posedge clk_i);
      #1;
    end
    uart_rx_i = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_ok);
    send_byte(b, stop_ok);
    repeat (6) @(posedge clk_i);
    #1;
    if (stop_ok) m_push(b);
    else m_ferr = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d, k;
    logic [7:0]  b9;
    logic [31:0] e;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    chk("rst_irq", 32'(rx_irq_o), 32'd0);
    bus(0, 3, 0, 32'h5EC0B0B1, "sanity");
    bus(0, 0, 0, 32'd1, "div_reset");
    bus(0, 2, 0, 32'd0, "status_reset");

    // Single byte at P=4.
    bus(1, 0, 32'd2, 0, "div_wr");
    m_div = 2;
    frame(8'hA5, 1);
    bus(0, 2, 0, status_exp(), "status_a5");
    chk("irq_a5", 32'(rx_irq_o), 32'd1);
    bus(0, 1, 0, rx_exp(), "rx_a5");
    bus(0, 1, 0, rx_exp(), "rx_empty");

    // Short glitch shorter than half a bit.
    uart_rx_i = 1'b0;
    @(posedge clk_i);
    #1;
    uart_rx_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    bus(0, 2, 0, status_exp(), "status_glitch");
    chk("irq_glitch", 32'(rx_irq_o), 32'd0);

    // Framing error, clear, then normal byte.
    frame(8'h3C, 0);
    bus(0, 2, 0, status_exp(), "status_ferr");
    chk("irq_ferr", 32'(rx_irq_o), 32'd1);
    bus(1, 2, 32'h2, 0, "ferr_clr");
    m_ferr = 0;
    bus(0, 2, 0, status_exp(), "status_ferr_clr");
    frame(8'h55, 1);
    bus(0, 1, 0, rx_exp(), "rx_55");

    // Overflow: nine bytes with no reads.
    for (int i = 0; i < 9; i++) frame(8'(i), 1);
    bus(0, 2, 0, status_exp(), "status_ovr");
    for (int i = 0; i < 9; i++) bus(0, 1, 0, rx_exp(), "rx_ovr");
    bus(0, 2, 0, status_exp(), "status_drained");
    bus(1, 2, 32'h1, 0, "ovr_clr");
    m_ovr = 0;
    bus(0, 2, 0, status_exp(), "status_ovr_clr");

    // Random dividers and bytes.
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(0, 4);
      k = $urandom_range(1, 3);
      bus(1, 0, 32'(d), 0, "rand_div_wr");
      m_div = int'(d);
      bus(0, 0, 0, 32'(m_div), "rand_div_rd");
      for (int j = 0; j < int'(k); j++) frame(8'($urandom), 1);
      bus(0, 2, 0, status_exp(), "rand_status");
      for (int j = 0; j <= int'(k); j++) bus(0, 1, 0, rx_exp(), "rand_rx");
    end

    // Full FIFO, ninth byte pushed on the same cycle as a pop.
    bus(1, 0, 32'd2, 0, "div_wr2");
    m_div = 2;
    for (int i = 0; i < 8; i++) frame(8'($urandom), 1);
    b9 = 8'($urandom);
    fork
      send_byte(b9, 1);
      begin
        repeat (40) @(posedge clk_i);
        #1;
        e = rx_exp();
        bus(0, 1, 0, e, "rx_simul");
      end
    join
    repeat (6) @(posedge clk_i);
    #1;
    m_push(b9);
    bus(0, 2, 0, status_exp(), "status_simul");
    chk("irq_full", 32'(rx_irq_o), 32'd1);

    // Asynchronous reset in the middle of a frame.
    uart_rx_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_irq", 32'(rx_irq_o), 32'd0);
    chk("arst_ack", 32'(wb_ack_o), 32'd0);
    chk("arst_data", wb_data_o, 32'd0);
    uart_rx_i = 1'b1;
    mq.delete();
    m_ovr = 0; m_ferr = 0; m_div = 1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    bus(0, 2, 0, status_exp(), "status_after_rst");
    bus(0, 0, 0, 32'(m_div), "div_after_rst");
    bus(0, 1, 0, rx_exp(), "rx_after_rst");
    repeat (2) @(posedge clk_i);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
